// File: rtl/counter_pkg.sv
// Shared constants for the parametrised tick/count counter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package counter_pkg;

  // End-of-range behaviour selected by the 2-bit mode input.
  // Encoding 2'b11 is reserved and treated as wrap.
  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  // Control FSM states.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

endpackage : counter_pkg

// File: rtl/tick_prescaler.sv
// Enable prescaler: emits one tick every PRESCALE enabled cycles.
// Latency: tick is combinational from en and the registered phase counter.
// Backpressure: none; phase holds while en is low, clr restarts the period.
//
// Ports:
//   trigger  - clock, rising edge
//   reset    - synchronous active-high reset (phase -> 0)
//   en       - advance the phase counter
//   clr      - synchronous phase clear (used by load)
//   tick     - en & (phase == PRESCALE-1)
module tick_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic trigger,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  // With PRESCALE = 1, LAST is 0 so cnt never leaves 0 and tick reduces to en.
  assign tick = en & (cnt == LAST);

  always_ff @(posedge trigger) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

endmodule : tick_prescaler

// File: rtl/mod_counter.sv
// Parametrised up/down counter with load, prescaler and wrap/saturate/one-shot ends.
// Latency: step or load in cycle N is visible on count, wrap and done after edge N+1.
// Backpressure: none; en gates stepping, steps in DONE are ignored.
//
// Ports:
//   trigger  - clock, rising edge
//   reset    - synchronous active-high reset
//   en       - enables prescaler and stepping
//   dir      - 1 = up, 0 = down (sampled per step)
//   mode     - 00 wrap, 01 saturate, 10 one-shot, 11 as wrap (sampled per step)
//   load     - synchronous load of min(load_val, MAX_VAL); returns to RUN
//   load_val - load value
//   count    - registered count, always 0..MAX_VAL
//   tc       - combinational terminal flag for the current direction
//   wrap     - registered one-cycle pulse when a wrapped value appears
//   done     - registered, high while the one-shot has finished
module mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_VAL  = (2 ** WIDTH) - 1,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             trigger,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             done
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             tick;
  logic [WIDTH-1:0] load_clamped;

  // Load clears the prescaler so the next step is a full period after the load.
  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .trigger (trigger),
    .reset   (reset),
    .en      (en),
    .clr     (load),
    .tick    (tick)
  );

  assign load_clamped = (load_val > MAX_W) ? MAX_W : load_val;

  assign tc = dir ? (count_q == MAX_W) : (count_q == '0);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wrap_d  = 1'b0;

    if (load) begin
      count_d = load_clamped;
      state_d = ST_RUN;
    end else if (tick && (state_q == ST_RUN)) begin
      if (!tc) begin
        count_d = dir ? (count_q + 1'b1) : (count_q - 1'b1);
      end else begin
        unique case (mode)
          MODE_SAT: begin
            count_d = count_q;
          end
          MODE_ONESHOT: begin
            // The step taken at the terminal value is what finishes the shot.
            state_d = ST_DONE;
          end
          default: begin
            count_d = dir ? '0 : MAX_W;
            wrap_d  = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge trigger) begin
    if (reset) begin
      state_q <= ST_RUN;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign done  = (state_q == ST_DONE);

endmodule : mod_counter
